// File: rtl/rom_boot_copier_pkg.sv
// Shared constants for the boot copier: header magic bytes and FSM state encoding.
package rom_boot_copier_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAGIC_LEN = 4;
    localparam int unsigned STATE_W   = 3;

    localparam logic [DATA_W-1:0] BOOT_MAGIC0 = 8'h41;
    localparam logic [DATA_W-1:0] BOOT_MAGIC1 = 8'h53;
    localparam logic [DATA_W-1:0] BOOT_MAGIC2 = 8'h52;
    localparam logic [DATA_W-1:0] BOOT_MAGIC3 = 8'h4D;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE = 3'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN = 3'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERROR = 3'd4;

    function automatic logic [DATA_W-1:0] boot_magic(input logic [1:0] idx);
        logic [DATA_W-1:0] b;
        case (idx)
            2'd0:    b = BOOT_MAGIC0;
            2'd1:    b = BOOT_MAGIC1;
            2'd2:    b = BOOT_MAGIC2;
            default: b = BOOT_MAGIC3;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rom_boot_copier.sv
// Copies the boot ROM image into CPU RAM after reset, checking the "ASRM" header,
// and keeps the CPU in reset until the copy has completed cleanly.
module rom_boot_copier
    import rom_boot_copier_pkg::*;
#(
    parameter int unsigned ROM_ADDR_W = 9,
    parameter int unsigned RAM_ADDR_W = 9,
    parameter int unsigned COPY_LEN   = 512,
    parameter int unsigned DEST_BASE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  rom_en,
    input  logic [DATA_W-1:0]     rom_data,
    output logic                  ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [ROM_ADDR_W-1:0] LAST_ADDR = ROM_ADDR_W'(COPY_LEN - 1);
    localparam logic [RAM_ADDR_W-1:0] BASE_ADDR = RAM_ADDR_W'(DEST_BASE);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic                  rom_en_q, rom_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]     ram_data_q, ram_data_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  bad_q, bad_d;
    logic                  p1_v_q, p1_v_d, p2_v_q, p2_v_d;
    logic [ROM_ADDR_W-1:0] p1_idx_q, p1_idx_d, p2_idx_q, p2_idx_d;

    logic                  start_run;
    logic                  hdr_bad;
    logic [ROM_ADDR_W-1:0] next_addr;

    // Next-state, pipeline and output logic
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        rom_en_d   = rom_en_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        error_d    = error_q;
        bad_d      = 1'b0;
        p1_v_d     = 1'b0;
        p1_idx_d   = p1_idx_q;
        p2_v_d     = p1_v_q;
        p2_idx_d   = p1_idx_q;
        start_run  = 1'b0;
        hdr_bad    = 1'b0;
        next_addr  = rom_addr_q + ROM_ADDR_W'(1);

        // Stage 2 holds the index whose ROM data is on rom_data now
        if (p2_v_q) begin
            if (p2_idx_q < ROM_ADDR_W'(MAGIC_LEN) && rom_data != boot_magic(p2_idx_q[1:0])) begin
                hdr_bad = 1'b1;
            end else begin
                ram_we_d   = 1'b1;
                ram_addr_d = BASE_ADDR + RAM_ADDR_W'(p2_idx_q);
                ram_data_d = rom_data;
            end
        end

        case (state_q)
            ST_IDLE:  start_run = 1'b1;
            ST_ISSUE: begin
                rom_addr_d = next_addr;
                p1_v_d     = 1'b1;
                p1_idx_d   = next_addr;
                if (next_addr == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!p1_v_q && !p2_v_q) begin
                    state_d    = ST_DONE;
                    rom_en_d   = 1'b0;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end
            end
            ST_DONE, ST_ERROR: start_run = restart;
            default:  state_d = ST_IDLE;
        endcase

        if (start_run) begin
            state_d    = ST_ISSUE;
            rom_addr_d = '0;
            rom_en_d   = 1'b1;
            p1_v_d     = 1'b1;
            p1_idx_d   = '0;
            done_d     = 1'b0;
            error_d    = 1'b0;
            cpu_hold_d = 1'b1;
        end

        // A bad header byte freezes issue for one edge, then the FSM parks in ERROR
        if (bad_q) begin
            state_d    = ST_ERROR;
            rom_addr_d = rom_addr_q;
            rom_en_d   = 1'b0;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
            p1_v_d     = 1'b0;
            p2_v_d     = 1'b0;
        end else if (hdr_bad) begin
            state_d    = state_q;
            rom_addr_d = rom_addr_q;
            bad_d      = 1'b1;
            p1_v_d     = 1'b0;
            p2_v_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            bad_q      <= 1'b0;
            p1_v_q     <= 1'b0;
            p1_idx_q   <= '0;
            p2_v_q     <= 1'b0;
            p2_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            rom_en_q   <= rom_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
            bad_q      <= bad_d;
            p1_v_q     <= p1_v_d;
            p1_idx_q   <= p1_idx_d;
            p2_v_q     <= p2_v_d;
            p2_idx_q   <= p2_idx_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rom_en   = rom_en_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
